// File: rtl/multi_phase_clkgen.sv
// Multi-phase divided-clock generator: NUM_PHASES registered logic-clocks spaced
// 360/NUM_PHASES degrees apart, runtime divide ratio, runt-free start/stop, per-period sync pulse.
module multi_phase_clkgen #(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = 8,
    localparam int S_W       = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIV_W-1:0]      div_cfg,
    output logic [NUM_PHASES-1:0] phase_out,
    output logic                  sync_pulse,
    output logic                  running
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [S_W-1:0]        S_LAST = S_W'(NUM_PHASES - 1);
    localparam logic [S_W-1:0]        S_HALF = S_W'(NUM_PHASES / 2);
    localparam logic [NUM_PHASES-1:0] BIT0   = NUM_PHASES'(1);

    state_t                  state_q, state_d;
    logic [S_W-1:0]          s_q, s_d;
    logic [DIV_W-1:0]        p_q, p_d;
    logic [DIV_W-1:0]        div_lat_q, div_lat_d;
    logic [NUM_PHASES-1:0]   armed_q, armed_d;
    logic [NUM_PHASES-1:0]   phase_q, phase_d;
    logic                    sync_q, sync_d;
    logic                    running_q, running_d;

    logic                    step;
    logic                    wrap;
    logic [NUM_PHASES-1:0]   raw_next;
    logic [NUM_PHASES-1:0]   arm_set;

    // Prescaler and step counter; they only depend on the registered FSM state.
    always_comb begin
        s_d       = s_q;
        p_d       = p_q;
        div_lat_d = div_lat_q;
        step      = 1'b0;
        wrap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    s_d       = '0;
                    p_d       = '0;
                    div_lat_d = div_cfg;
                end
            end
            default: begin
                if (p_q == div_lat_q) begin
                    step = 1'b1;
                    p_d  = '0;
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        wrap = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
                // A new ratio only takes effect at a period boundary while running.
                if ((state_q == ST_RUN) && wrap) begin
                    div_lat_d = div_cfg;
                end
            end
        endcase
    end

    // Phase k is high for the half period starting where s becomes k.
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
        localparam logic [S_W-1:0] K      = S_W'(gi);
        localparam logic [S_W-1:0] K_WRAP = S_W'(NUM_PHASES - gi);
        assign raw_next[gi] = (s_d >= K) ? ((s_d - K) < S_HALF)
                                         : ((s_d + K_WRAP) < S_HALF);
        assign arm_set[gi]  = step & (s_d == K);
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        phase_d   = phase_q;
        sync_d    = 1'b0;
        running_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                    armed_d = BIT0;
                    phase_d = raw_next & BIT0;
                    sync_d  = 1'b1;
                end
            end
            ST_RUN: begin
                armed_d = armed_q | arm_set;
                if (en) begin
                    phase_d = raw_next & armed_d;
                    sync_d  = step & (s_d == '0);
                end else begin
                    // Stop mask: outputs may only fall from here on.
                    phase_d = raw_next & phase_q;
                    state_d = (phase_d == '0) ? ST_IDLE : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                phase_d = raw_next & phase_q;
                if (phase_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            p_q       <= '0;
            div_lat_q <= '0;
            armed_q   <= '0;
            phase_q   <= '0;
            sync_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            p_q       <= p_d;
            div_lat_q <= div_lat_d;
            armed_q   <= armed_d;
            phase_q   <= phase_d;
            sync_q    <= sync_d;
            running_q <= running_d;
        end
    end

    assign phase_out  = phase_q;
    assign sync_pulse = sync_q;
    assign running    = running_q;

endmodule

// File: tb/tb_multi_phase_clkgen.sv
// Testbench for multi_phase_clkgen: directed start/stop/reset scenarios plus randomized
// en/div_cfg traffic, all checked against an arithmetic reference model.
module tb_multi_phase_clkgen;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] div_cfg = '0;
    logic [N-1:0]  phase_out;
    logic          sync_pulse;
    logic          running;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0=idle, 1=run, 2=stopping; masks are plain ints.
    int m_mode, m_s, m_p, m_div, m_armed, m_phase, m_sync;

    always #5 clk = ~clk;

    multi_phase_clkgen #(.NUM_PHASES(N), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_cfg    (div_cfg),
        .phase_out  (phase_out),
        .sync_pulse (sync_pulse),
        .running    (running)
    );

    function automatic int raw_of(int s);
        int r = 0;
        for (int k = 0; k < N; k++)
            if ((((s - k) % N) + N) % N < N / 2) r |= (1 << k);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_s = 0; m_p = 0; m_div = 0;
        m_armed = 0; m_phase = 0; m_sync = 0;
    endtask

    task automatic model_edge();
        int step;
        int wrap;
        if (!rst) begin
            model_reset();
            return;
        end
        m_sync = 0;
        if (m_mode == 0) begin
            if (en) begin
                m_mode = 1; m_s = 0; m_p = 0; m_div = int'(div_cfg);
                m_armed = 1; m_phase = raw_of(0) & 1; m_sync = 1;
            end else begin
                m_phase = 0;
            end
            return;
        end
        step = (m_p == m_div) ? 1 : 0;
        wrap = (step != 0 && m_s == N - 1) ? 1 : 0;
        if (step != 0) begin
            m_p = 0;
            m_s = (m_s + 1) % N;
        end else begin
            m_p++;
        end
        if (m_mode == 1) begin
            if (wrap != 0) m_div = int'(div_cfg);
            if (step != 0) m_armed |= (1 << m_s);
            if (en) begin
                m_phase = raw_of(m_s) & m_armed;
                m_sync  = (step != 0 && m_s == 0) ? 1 : 0;
            end else begin
                m_phase = raw_of(m_s) & m_phase;
                m_mode  = (m_phase != 0) ? 2 : 0;
            end
        end else begin
            m_phase = raw_of(m_s) & m_phase;
            if (m_phase == 0) m_mode = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"},   {28'b0, phase_out}, m_phase);
        chk({tag, ".sync"},    {31'b0, sync_pulse}, m_sync);
        chk({tag, ".running"}, {31'b0, running}, (m_mode != 0) ? 1 : 0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic tick_d(input string tag, input logic [3:0] ph, input logic sp, input logic rn);
        tick(tag);
        chk({tag, ".dphase"},   {28'b0, phase_out}, {28'b0, ph});
        chk({tag, ".dsync"},    {31'b0, sync_pulse}, {31'b0, sp});
        chk({tag, ".drunning"}, {31'b0, running}, {31'b0, rn});
    endtask

    task automatic drain(input string tag);
        en = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick(tag);
            if (m_mode == 0) break;
        end
        tick(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq2 [6];
        logic [3:0] seq3 [4];
        seq2 = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
        seq3 = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};

        // Asynchronous reset takes effect before any clock edge.
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("async_rst.phase",   {28'b0, phase_out}, 32'h0);
        chk("async_rst.sync",    {31'b0, sync_pulse}, 32'h0);
        chk("async_rst.running", {31'b0, running}, 32'h0);
        tick("rst_hold");
        tick("rst_hold");
        rst = 1'b1;
        tick_d("idle", 4'b0000, 1'b0, 1'b0);
        tick_d("idle", 4'b0000, 1'b0, 1'b0);

        // Divide-by-1 start sequence, then stop while 0011 is showing.
        en = 1'b1;
        div_cfg = 8'd0;
        for (int i = 0; i < 6; i++)
            tick_d("div0_run", seq2[i], (i % 4) == 0, 1'b1);
        en = 1'b0;
        tick_d("stop_a", 4'b0010, 1'b0, 1'b1);
        tick_d("stop_b", 4'b0000, 1'b0, 1'b0);
        tick_d("stop_idle", 4'b0000, 1'b0, 1'b0);

        // en raised during STOPPING is ignored until IDLE.
        en = 1'b1;
        tick_d("re_a", 4'b0001, 1'b1, 1'b1);
        tick_d("re_b", 4'b0011, 1'b0, 1'b1);
        en = 1'b0;
        tick_d("re_stop", 4'b0010, 1'b0, 1'b1);
        en = 1'b1;
        tick_d("re_idle", 4'b0000, 1'b0, 1'b0);
        tick_d("re_start", 4'b0001, 1'b1, 1'b1);
        tick_d("re_next", 4'b0011, 1'b0, 1'b1);
        drain("re_drain");

        // Divide-by-3, then ratio change mid-period.
        div_cfg = 8'd2;
        en = 1'b1;
        for (int i = 0; i < 12; i++)
            tick_d("div2_run", seq3[i / 3], i == 0, 1'b1);
        for (int i = 0; i < 4; i++) tick("div2_p2");
        div_cfg = 8'd0;
        for (int i = 0; i < 20; i++) tick("div_change");

        // Reset mid-run aborts immediately; restart is clean.
        @(posedge clk);
        model_edge();
        #1;
        check_model("pre_rst");
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst.phase",   {28'b0, phase_out}, 32'h0);
        chk("mid_rst.running", {31'b0, running}, 32'h0);
        tick("mid_rst_hold");
        tick("mid_rst_hold");
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            tick_d("post_rst", seq3[i], i == 0, 1'b1);
        drain("post_rst_drain");

        // Longest period.
        div_cfg = 8'hFF;
        en = 1'b1;
        for (int i = 0; i < 4 * 256 + 20; i++) tick("div_max");
        drain("div_max_drain");

        // Randomized en and div_cfg traffic.
        div_cfg = 8'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0)
                div_cfg = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15))
                                                      : 8'($urandom_range(0, 3));
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
